// File: rtl/multicycle_comparator.sv
// Multicycle magnitude comparator: walks the captured operands MSB-first, CHUNK bits
// per cycle, and stops at the first differing chunk. Supports unsigned and two's-complement.
module multicycle_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sm_q, sm_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               g_q, g_d;
    logic               e_q, e_d;
    logic               l_q, l_d;

    logic [CHUNK-1:0]   cur_a;
    logic [CHUNK-1:0]   cur_b;

    // Select the current chunk; in signed mode flip the sign bit so an unsigned compare orders correctly.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_a = a_q[(NCH - 1 - i) * CHUNK +: CHUNK];
                cur_b = b_q[(NCH - 1 - i) * CHUNK +: CHUNK];
            end
        end
        if (sm_q && (idx_q == '0)) begin
            cur_a[CHUNK-1] = ~cur_a[CHUNK-1];
            cur_b[CHUNK-1] = ~cur_b[CHUNK-1];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        done_d  = 1'b0;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    idx_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (cur_a != cur_b) begin
                    g_d     = (cur_a > cur_b);
                    l_d     = (cur_a < cur_b);
                    e_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    e_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign g    = g_q;
    assign e    = e_q;
    assign l    = l_q;

endmodule

// File: tb/tb_multicycle_comparator.sv
// Bench for multicycle_comparator: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_multicycle_comparator;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         busy, done, g, e, l;

    int total = 0;
    int bad   = 0;

    multicycle_comparator #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .g(g), .e(e), .l(l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Edges from accept to done: one plus the index of the first differing chunk.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int p;
        d = x ^ y;
        if (d == '0) return NCH;
        p = 0;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        return (W - 1 - p) / CH + 1;
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        if (sm) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
        end else begin
            if (x > y) return 3'b100;
            if (x < y) return 3'b001;
        end
        return 3'b010;
    endfunction

    // Reference model: a latency countdown delivering the arithmetic result.
    logic       m_busy, m_done, m_g, m_e, m_l, m_started;
    int         m_cnt;
    logic [2:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_started <= 1'b0;
            m_g <= 1'b0; m_e <= 1'b0; m_l <= 1'b0;
            m_cnt <= 0; m_res <= 3'b000;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_g, m_e, m_l} <= m_res;
                    m_started <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= ref_lat(a, b);
                m_res  <= ref_cmp(a, b, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("g", 32'(g), 32'(m_g));
        chk("e", 32'(e), 32'(m_e));
        chk("l", 32'(l), 32'(m_l));
        if (m_started) chk("onehot", 32'(g) + 32'(e) + 32'(l), 32'd1);
    end

    // Called just after a rising edge with the DUT idle or showing done; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sm);
        a = xa; b = xb; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done; optionally fires a stray start with new operands mid-operation.
    task automatic wait_done(input bit inj, output int n);
        bit got;
        n = 0; got = 0;
        repeat (40) begin
            if (!got) begin
                @(posedge clk); #1;
                n++;
                if (done) begin
                    got = 1;
                    start = 1'b0;
                end else if (inj && n == 1) begin
                    start = 1'b1; a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b1;
                end else if (inj && n == 2) begin
                    start = 1'b0;
                end
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic sm, input bit inj, input int exp_lat, input logic [2:0] exp_gel);
        int n;
        start_op(xa, xb, sm);
        wait_done(inj, n);
        chk({name, "_lat"}, 32'(n), 32'(exp_lat));
        chk({name, "_gel"}, 32'({g, e, l}), 32'(exp_gel));
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        logic rs;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'({busy, done, g, e, l}), 32'd0);
        rst_n = 1'b1;

        op("eq_1234", 16'h1234, 16'h1234, 1'b0, 1'b0, 4, 3'b010);
        op("u_8000",  16'h8000, 16'h0001, 1'b0, 1'b0, 1, 3'b100);
        op("s_8000",  16'h8000, 16'h0001, 1'b1, 1'b0, 1, 3'b001);
        op("u_12f4",  16'h12F4, 16'h12F5, 1'b0, 1'b1, 4, 3'b001);
        op("s_ffff",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 3'b001);
        op("s_7fff",  16'h7FFF, 16'h8000, 1'b1, 1'b0, 1, 3'b100);

        // Back-to-back: new start issued during the done cycle; prior result must hold.
        op("b2b_first", 16'h1234, 16'h1234, 1'b0, 1'b0, 4, 3'b010);
        start_op(16'h0010, 16'h0001, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold", 32'({g, e, l}), 32'(3'b010));
        wait_done(1'b0, n);
        chk("b2b_lat", 32'(n), 32'd3);
        chk("b2b_gel", 32'({g, e, l}), 32'(3'b100));

        // Asynchronous reset in the second compare cycle.
        start_op(16'h1111, 16'h1111, 1'b0);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({busy, done, g, e, l}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nodone", 32'({busy, done}), 32'd0);
        rst_n = 1'b1;
        op("post_rst", 16'h0100, 16'h0200, 1'b0, 1'b0, 2, 3'b001);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ (16'd1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            start_op(ra, rb, rs);
            wait_done(1'b0, n);
            chk("rand_lat", 32'(n), 32'(ref_lat(ra, rb)));
            chk("rand_gel", 32'({g, e, l}), 32'(ref_cmp(ra, rb, rs)));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
